vote_result_reporter: RTL and testbench
=======================================

Name: vote_result_reporter

Overview:
- Downstream consumer of the four per-candidate 8-bit vote counters.
- On a report request in results mode, snapshots all four counts, finds the winner(s) sequentially, then presents a timed LED sequence: a winner frame followed by each candidate's count.
- Exposes registered winner/tie results and busy/done status to the top-level votingMachine.
- Replaces the single-press count display when a full announcement is wanted.

Parameters:
- CW, 8, count width and LED width in bits.
- DWELL, 5, clock cycles each frame is held on led; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mode  input  1  1 = results mode; 0 = voting mode.
- report_req  input  1  single-cycle request pulse, e.g. a debounced valid strobe.
- count1..count4  input  CW each  live vote counts for candidates 1..4.
- led  output  CW  frame being presented.
- winner  output  4  one-hot or multi-hot mask of leading candidate(s); bit0 = cand1.
- tie  output  1  more than one candidate shares a nonzero maximum.
- busy  output  1  high from the request-accept edge until the return to IDLE.
- done  output  1  one-cycle pulse at the end of a completed sequence.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; led, winner, tie, busy, done, snapshots, max, mask and dwell counter all 0. Takes effect immediately, including mid-sequence.
- FSM states: IDLE, CMP, WIN, CNT0, CNT1, CNT2, CNT3, DONE.
- IDLE:
  - report_req=1 with mode=1 at edge N: snapshot count1..4, clear max and mask, set compare index to 0, go to CMP, busy=1.
  - report_req with mode=0 is ignored.
- CMP: one candidate per cycle, index 0..3, at edges N+1..N+4.
  - If snap[i] > max: max=snap[i], mask=only bit i.
  - Else if snap[i] == max and max != 0: set bit i in mask.
  - Unsigned compare; no arithmetic overflow is possible.
- After edge N+4: winner=mask, tie=(popcount(mask) > 1), state=WIN. led={mask, tie, zeros} with winner in led[CW-1:CW-4], tie in led[CW-5], remaining bits 0.
- All counts 0: winner=0000, tie=0, winner frame led=0.
- WIN, CNT0..CNT3: each state is held exactly DWELL cycles via a dwell counter that resets on every state change.
  - CNTi drives led=snap[i].
  - Order: WIN -> CNT0 -> CNT1 -> CNT2 -> CNT3 -> DONE.
- DONE: lasts one cycle with done=1, led=0, busy still 1; next edge goes to IDLE with busy=0.
  - done is high after edge N+4+5*DWELL; IDLE is reached after edge N+5+5*DWELL.
  - With DWELL=5: done after edge N+29, busy falls after edge N+30.
- Snapshot isolation: changes on count1..4 after edge N do not affect this sequence.
- report_req while busy: ignored; no queuing or restart.
- mode falling to 0 while busy, in any state other than IDLE: at the next edge go to IDLE; led=0, busy=0, no done pulse.
  - winner and tie keep their previous values if the abort happens before WIN is reached; otherwise they keep the new values.
- winner and tie hold until the next completed compare or reset.
- led=0 in IDLE.

Test Plan:
- Distinct winner: counts 3,7,2,7 -> wait, use 3,9,2,7 with DWELL=5 and request at edge N. Required: winner=0010, tie=0; led=8'h20 during cycles N+4..N+8, then 3,9,2,7 for 5 cycles each; done pulse after edge N+29; busy=0 after edge N+30.
- Tie: counts 5,1,5,5 -> winner=1101, tie=1, winner frame led=8'hD8; then the count frames 5,1,5,5.
- No votes: all counts 0 -> winner=0000, tie=0, led=0 during WIN; the sequence still completes and done pulses.
- Snapshot and overlap:
  - Change count1 from 4 to 200 one cycle after the request -> CNT0 frame shows 4.
  - A second report_req during CNT1 -> ignored; exactly one done pulse.
  - report_req with mode=0 -> busy stays 0.
- Abort and reset:
  - Drop mode during CNT2 -> next cycle state=IDLE, led=0, busy=0, no done pulse; winner retains this run's value.
  - Assert reset asynchronously mid-WIN (between clock edges) -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vote_result_reporter.sv
// vote_result_reporter: snapshots the four candidate counters on a report
// request, finds the leading candidate(s) one candidate per cycle, then walks
// the LEDs through a winner frame and each candidate's count, every frame
// held for DWELL cycles. Winner/tie results stay registered between reports.
module vote_result_reporter #(
  parameter int CW    = 8,
  parameter int DWELL = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          report_req,
  input  logic [CW-1:0] count1,
  input  logic [CW-1:0] count2,
  input  logic [CW-1:0] count3,
  input  logic [CW-1:0] count4,
  output logic [CW-1:0] led,
  output logic [3:0]    winner,
  output logic          tie,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_WIN,
    S_CNT0,
    S_CNT1,
    S_CNT2,
    S_CNT3,
    S_DONE
  } state_t;

  state_t              r_state, w_state_next;
  logic [3:0][CW-1:0]  w_counts;
  logic [3:0][CW-1:0]  r_snap;
  logic                w_load;
  logic [CW-1:0]       r_max, w_max_next;
  logic [3:0]          r_mask, w_mask_next;
  logic [1:0]          r_idx, w_idx_next;
  logic [7:0]          r_dwell, w_dwell_next;
  logic [CW-1:0]       r_led, w_led_next;
  logic [3:0]          r_winner, w_winner_next;
  logic                r_tie, w_tie_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;

  // Compare datapath for the candidate currently being examined
  logic [CW-1:0]       w_cur;
  logic [3:0]          w_bit;
  logic [CW-1:0]       w_max_upd;
  logic [3:0]          w_mask_upd;
  logic [2:0]          w_pop;
  logic                w_tie_upd;
  logic [CW-1:0]       w_frame;
  logic                w_dwell_last;

  // Element 0 is candidate 1
  assign w_counts = {count4, count3, count2, count1};

  assign w_cur = r_snap[r_idx];
  assign w_bit = 4'b0001 << r_idx;

  // Running maximum / leader mask after folding in candidate r_idx
  always_comb begin
    w_max_upd  = r_max;
    w_mask_upd = r_mask;
    if (w_cur > r_max) begin
      w_max_upd  = w_cur;
      w_mask_upd = w_bit;
    end else if ((w_cur == r_max) && (r_max != '0)) begin
      w_mask_upd = r_mask | w_bit;
    end
  end

  assign w_pop = 3'(w_mask_upd[0]) + 3'(w_mask_upd[1]) +
                 3'(w_mask_upd[2]) + 3'(w_mask_upd[3]);
  assign w_tie_upd = (w_pop > 3'd1);

  // Winner frame: mask in the top nibble, tie flag just below, rest zero
  always_comb begin
    w_frame            = '0;
    w_frame[CW-1 -: 4] = w_mask_upd;
    w_frame[CW-5]      = w_tie_upd;
  end

  assign w_dwell_last = (r_dwell == 8'(DWELL - 1));

  // Next-state and next-output decode; a mode drop outside IDLE aborts
  always_comb begin
    w_state_next  = r_state;
    w_max_next    = r_max;
    w_mask_next   = r_mask;
    w_idx_next    = r_idx;
    w_dwell_next  = r_dwell;
    w_led_next    = r_led;
    w_winner_next = r_winner;
    w_tie_next    = r_tie;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_load        = 1'b0;

    if ((r_state != S_IDLE) && !mode) begin
      // Abort: winner/tie are left as they are (updated only on WIN entry)
      w_state_next = S_IDLE;
      w_led_next   = '0;
      w_busy_next  = 1'b0;
      w_dwell_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (report_req && mode) begin
            w_load       = 1'b1;
            w_max_next   = '0;
            w_mask_next  = '0;
            w_idx_next   = '0;
            w_dwell_next = '0;
            w_busy_next  = 1'b1;
            w_state_next = S_CMP;
          end
        end
        S_CMP: begin
          w_max_next  = w_max_upd;
          w_mask_next = w_mask_upd;
          w_idx_next  = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_winner_next = w_mask_upd;
            w_tie_next    = w_tie_upd;
            w_led_next    = w_frame;
            w_dwell_next  = '0;
            w_state_next  = S_WIN;
          end
        end
        S_WIN, S_CNT0, S_CNT1, S_CNT2, S_CNT3: begin
          if (!w_dwell_last) begin
            w_dwell_next = r_dwell + 8'd1;
          end else begin
            w_dwell_next = '0;
            case (r_state)
              S_WIN: begin
                w_state_next = S_CNT0;
                w_led_next   = r_snap[0];
              end
              S_CNT0: begin
                w_state_next = S_CNT1;
                w_led_next   = r_snap[1];
              end
              S_CNT1: begin
                w_state_next = S_CNT2;
                w_led_next   = r_snap[2];
              end
              S_CNT2: begin
                w_state_next = S_CNT3;
                w_led_next   = r_snap[3];
              end
              default: begin
                w_state_next = S_DONE;
                w_led_next   = '0;
                w_done_next  = 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_led_next   = '0;
          w_busy_next  = 1'b0;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_max    <= '0;
      r_mask   <= '0;
      r_idx    <= '0;
      r_dwell  <= '0;
      r_led    <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_max    <= w_max_next;
      r_mask   <= w_mask_next;
      r_idx    <= w_idx_next;
      r_dwell  <= w_dwell_next;
      r_led    <= w_led_next;
      r_winner <= w_winner_next;
      r_tie    <= w_tie_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  // Count snapshot, isolated from live counters for the whole sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
    end else if (w_load) begin
      r_snap <= w_counts;
    end
  end

  assign led    = r_led;
  assign winner = r_winner;
  assign tie    = r_tie;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Bench for vote_result_reporter: directed report sequences checked every
// cycle against a timeline model, plus literal spot checks.
module tb_vote_result_reporter;

  localparam int CW     = 8;
  localparam int DWELL  = 5;
  localparam int DONE_K = 4 + 5 * DWELL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic          report_req = 1'b0;
  logic [CW-1:0] count1 = '0, count2 = '0, count3 = '0, count4 = '0;
  logic [CW-1:0] led;
  logic [3:0]    winner;
  logic          tie, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  vote_result_reporter #(.CW(CW), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .mode(mode), .report_req(report_req),
    .count1(count1), .count2(count2), .count3(count3), .count4(count4),
    .led(led), .winner(winner), .tie(tie), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts edges since the accepting edge of the request
  logic          m_active = 1'b0;
  int            m_k = 0;
  logic [CW-1:0] m_snap [4] = '{default: '0};
  logic [3:0]    m_win = '0;
  logic          m_tie = 1'b0;

  function automatic logic [3:0] lead_mask(input logic [CW-1:0] a, b, c, d);
    logic [CW-1:0] v [4];
    logic [CW-1:0] mx;
    logic [3:0]    m;
    v = '{a, b, c, d};
    mx = '0;
    m = '0;
    for (int i = 0; i < 4; i++) if (v[i] > mx) mx = v[i];
    for (int i = 0; i < 4; i++) if (mx != 0 && v[i] == mx) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] exp_led();
    if (!m_active || m_k < 4 || m_k >= DONE_K) return '0;
    if (m_k < 4 + DWELL) return {m_win, m_tie, {(CW-5){1'b0}}};
    return m_snap[(m_k - 4 - DWELL) / DWELL];
  endfunction

  // Model timeline update
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_win    <= '0;
      m_tie    <= 1'b0;
    end else if (!m_active) begin
      if (report_req && mode) begin
        m_active  <= 1'b1;
        m_k       <= 0;
        m_snap[0] <= count1;
        m_snap[1] <= count2;
        m_snap[2] <= count3;
        m_snap[3] <= count4;
      end
    end else if (!mode) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == 4) begin
        m_win <= lead_mask(m_snap[0], m_snap[1], m_snap[2], m_snap[3]);
        m_tie <= ($countones(lead_mask(m_snap[0], m_snap[1], m_snap[2], m_snap[3])) > 1);
      end
      if (m_k + 1 == DONE_K + 1) m_active <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_busy", busy, m_active);
    chk("m_done", done, (m_active && m_k == DONE_K));
    chk("m_led", led, exp_led());
    chk("m_winner", winner, m_win);
    chk("m_tie", tie, m_tie);
  end

  // Done pulse counter
  always @(negedge clk) if (done) done_cnt++;

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge right after the accepting edge (k=0)
  task automatic request(input logic [CW-1:0] c1, c2, c3, c4);
    @(negedge clk);
    count1 = c1; count2 = c2; count3 = c3; count4 = c4;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    $display("request counts %0d %0d %0d %0d", c1, c2, c3, c4);
  endtask

  int d0;

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_led", led, 8'h00);
    chk("rst_winner", winner, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    waitn(2);
    reset = 1'b1;
    mode  = 1'b1;
    waitn(2);

    // Distinct winner
    request(3, 9, 2, 7);
    chk("d_busy_k0", busy, 1'b1);
    waitn(4);
    chk("d_frame", led, 8'h20);
    chk("d_winner", winner, 4'b0010);
    chk("d_tie", tie, 1'b0);
    waitn(4); chk("d_frame_k8", led, 8'h20);
    waitn(1); chk("d_cnt0", led, 8'd3);
    waitn(5); chk("d_cnt1", led, 8'd9);
    waitn(5); chk("d_cnt2", led, 8'd2);
    waitn(5); chk("d_cnt3", led, 8'd7);
    waitn(4); chk("d_nodone_k28", done, 1'b0);
    waitn(1);
    chk("d_done_k29", done, 1'b1);
    chk("d_busy_k29", busy, 1'b1);
    chk("d_led_k29", led, 8'h00);
    waitn(1);
    chk("d_busy_k30", busy, 1'b0);
    chk("d_done_k30", done, 1'b0);

    // Three-way tie
    request(5, 1, 5, 5);
    waitn(4);
    chk("t_frame", led, 8'hD8);
    chk("t_winner", winner, 4'b1101);
    chk("t_tie", tie, 1'b1);
    waitn(5); chk("t_cnt0", led, 8'd5);
    waitn(5); chk("t_cnt1", led, 8'd1);
    waitn(15); chk("t_done", done, 1'b1);
    waitn(1);

    // No votes
    request(0, 0, 0, 0);
    waitn(4);
    chk("z_frame", led, 8'h00);
    chk("z_winner", winner, 4'b0000);
    chk("z_tie", tie, 1'b0);
    chk("z_busy", busy, 1'b1);
    waitn(25); chk("z_done", done, 1'b1);
    waitn(1);

    // Snapshot isolation and overlapping request
    d0 = done_cnt;
    request(4, 1, 1, 1);
    count1 = 8'd200;
    waitn(4);
    chk("s_winner", winner, 4'b0001);
    chk("s_frame", led, 8'h10);
    waitn(5); chk("s_cnt0", led, 8'd4);
    waitn(6);
    report_req = 1'b1;
    waitn(1);
    report_req = 1'b0;
    waitn(13); chk("s_done", done, 1'b1);
    waitn(4);
    chk("s_one_done", done_cnt - d0, 1);
    chk("s_idle_busy", busy, 1'b0);

    // Request in voting mode is ignored
    @(negedge clk);
    mode = 1'b0; report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    chk("v_busy", busy, 1'b0);
    waitn(2);
    chk("v_busy_later", busy, 1'b0);
    mode = 1'b1;
    $display("voting-mode request issued");

    // Abort by mode drop during CNT2
    d0 = done_cnt;
    request(2, 3, 8, 1);
    waitn(20);
    chk("a_cnt2", led, 8'd8);
    mode = 1'b0;
    waitn(1);
    chk("a_busy", busy, 1'b0);
    chk("a_led", led, 8'h00);
    chk("a_winner", winner, 4'b0100);
    waitn(3);
    chk("a_no_done", done_cnt - d0, 0);
    mode = 1'b1;

    // Asynchronous reset in the middle of WIN
    request(6, 6, 0, 0);
    waitn(6);
    chk("r_frame", led, 8'h38);
    #2 reset = 1'b0;
    #1;
    chk("r_led", led, 8'h00);
    chk("r_winner", winner, 4'b0000);
    chk("r_tie", tie, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_done", done, 1'b0);
    $display("async reset mid-WIN applied");
    waitn(2);
    reset = 1'b1;
    waitn(3);
    chk("r_after_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
